// File: rtl/nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor
//
// Sequential 16-bit subtractor: D = A - B - bin, one 4-bit nibble per clock,
// least significant nibble first. A single registered borrow ripples between
// nibbles. The result, the unsigned borrow-out and the signed overflow flag
// are published together with a one-cycle done pulse.
//
// Ports:
//   Clk      in   1   rising-edge clock
//   Reset_n  in   1   asynchronous active-low reset
//   start    in   1   request; sampled only while ready=1
//   A        in  16   minuend, captured on the accepted start edge
//   B        in  16   subtrahend, captured on the accepted start edge
//   bin      in   1   borrow-in, captured on the accepted start edge
//   ready    out  1   high in IDLE and DONE (new start accepted)
//   done     out  1   one-cycle pulse; D/bout/V updated and valid
//   D        out 16   difference, held until the next done
//   bout     out  1   unsigned borrow-out (A < B + bin)
//   V        out  1   two's-complement overflow of the raw result
//
// Optional feature macro: SUB_SATURATE_EN
//   Defined   : on overflow D saturates to 0x7FFF (A positive) or 0x8000
//               (A negative); bout and V still describe the raw result.
//   Undefined : D is always the wrapped modulo-2^16 result.
// -----------------------------------------------------------------------------
module nibble_serial_subtractor (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        bin,
    output logic        ready,
    output logic        done,
    output logic [15:0] D,
    output logic        bout,
    output logic        V
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_borrow;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_res;
    logic        r_ready;
    logic        r_done;
    logic [15:0] r_d;
    logic        r_bout;
    logic        r_v;

    logic [3:0]  w_a_nib;
    logic [3:0]  w_b_nib;
    logic [4:0]  w_sub;
    logic [15:0] w_res_next;
    logic        w_v;
    logic        w_accept;

    // 5-bit nibble subtract: bit 4 is the borrow out of this nibble.
    function automatic logic [4:0] f_nib_sub(input logic [3:0] a_nib,
                                             input logic [3:0] b_nib,
                                             input logic       bw);
        return {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, bw};
    endfunction

`ifdef SUB_SATURATE_EN
    // Clamp toward the sign of the minuend when the raw result overflowed.
    function automatic logic [15:0] f_sat(input logic [15:0] raw,
                                          input logic        ovf,
                                          input logic        a_msb);
        if (ovf) begin
            return a_msb ? 16'h8000 : 16'h7FFF;
        end
        return raw;
    endfunction
`endif

    assign w_a_nib  = r_a[{r_cnt, 2'b00} +: 4];
    assign w_b_nib  = r_b[{r_cnt, 2'b00} +: 4];
    assign w_sub    = f_nib_sub(w_a_nib, w_b_nib, r_borrow);
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Result register with the current nibble merged in; on the last nibble
    // this is the complete raw difference, so D and V can load on that edge.
    always_comb begin
        w_res_next                        = r_res;
        w_res_next[{r_cnt, 2'b00} +: 4]   = w_sub[3:0];
    end

    assign w_v = (r_a[15] != r_b[15]) && (w_res_next[15] != r_a[15]);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 2'd0;
            r_borrow <= 1'b0;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_res    <= 16'h0000;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_d      <= 16'h0000;
            r_bout   <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= bin;
                        r_cnt    <= 2'd0;
                        r_ready  <= 1'b0;
                        r_state  <= S_RUN;
                    end else begin
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end

                S_RUN: begin
                    // start is ignored here; operands stay frozen.
                    r_res    <= w_res_next;
                    r_borrow <= w_sub[4];
                    r_cnt    <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
`ifdef SUB_SATURATE_EN
                        r_d  <= f_sat(w_res_next, w_v, r_a[15]);
`else
                        r_d  <= w_res_next;
`endif
                        r_bout  <= w_sub[4];
                        r_v     <= w_v;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign D     = r_d;
    assign bout  = r_bout;
    assign V     = r_v;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// Testbench for nibble_serial_subtractor. Expected results come from a
// full-width reference subtract, are queued when an operation is launched and
// popped by a monitor whenever the DUT raises done.
// -----------------------------------------------------------------------------
module tb_nibble_serial_subtractor;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        bin;
    logic        ready;
    logic        done;
    logic [15:0] D;
    logic        bout;
    logic        V;

    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        v;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_vec = 0;
    int   n_err = 0;

    nibble_serial_subtractor dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .bin     (bin),
        .ready   (ready),
        .done    (done),
        .D       (D),
        .bout    (bout),
        .V       (V)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bi);
        logic [16:0] diff;
        exp_t        e;
        diff   = {1'b0, a} - {1'b0, b} - {16'h0000, bi};
        e.d    = diff[15:0];
        e.bout = diff[16];
        e.v    = (a[15] != b[15]) && (diff[15] != a[15]);
`ifdef SUB_SATURATE_EN
        if (e.v) e.d = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always @(negedge Clk) begin
        if (Reset_n && done) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done D=%h bout=%b V=%b, no result expected", D, bout, V);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (D !== e.d || bout !== e.bout || V !== e.v || ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL result D=%h bout=%b V=%b ready=%b, expected D=%h bout=%b V=%b ready=1",
                             D, bout, V, ready, e.d, e.bout, e.v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive a request and hold it through the next rising edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bi);
        start = 1'b1;
        A     = a;
        B     = b;
        bin   = bi;
        last_exp = model(a, b, bi);
        sb.push_back(last_exp);
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    // Count falling edges until done is seen; leaves time at that falling edge.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            cyc++;
            if (done === 1'b1) return;
        end
        cyc = -1;
    endtask

    task automatic run_op(input string name, input logic [15:0] a,
                          input logic [15:0] b, input logic bi);
        int cyc;
        launch(a, b, bi);
        wait_done(cyc);
        n_vec++;
        if (cyc != 5) begin
            n_err++;
            $display("FAIL %s_latency cycles=%0d, expected 5", name, cyc);
        end
        tick();
    endtask

    task automatic test_reset();
        Reset_n = 1'b1;
        start = 1'b0; A = 16'h0; B = 16'h0; bin = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        n_vec++;
        if (ready !== 1'b1 || done !== 1'b0 || D !== 16'h0000 || bout !== 1'b0 || V !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state ready=%b done=%b D=%h bout=%b V=%b, expected 1 0 0000 0 0",
                     ready, done, D, bout, V);
        end
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op("basic", 16'h1234, 16'h0034, 1'b0);
        run_op("mixed", 16'hA5C3, 16'h3C5A, 1'b1);
    endtask

    task automatic test_borrow_ripple();
        run_op("ripple0", 16'h0000, 16'h0001, 1'b0);
        run_op("ripple1", 16'h0005, 16'h0005, 1'b1);
        run_op("zero",    16'hFFFF, 16'hFFFF, 1'b0);
    endtask

    task automatic test_overflow();
        run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0);
        run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0);
    endtask

    task automatic test_reset_midrun();
        launch(16'h4321, 16'h1111, 1'b0);
        tick();
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL run_ready ready=%b, expected 0", ready);
        end
        Reset_n = 1'b0;
        sb.delete();
        #1;
        n_vec++;
        if (ready !== 1'b1 || done !== 1'b0 || D !== 16'h0000 || bout !== 1'b0 || V !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset ready=%b done=%b D=%h bout=%b V=%b, expected 1 0 0000 0 0",
                     ready, done, D, bout, V);
        end
        tick();
        Reset_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge Clk);
                if (done !== 1'b0) seen++;
            end
            n_vec++;
            if (seen != 0) begin
                n_err++;
                $display("FAIL abort_no_done done_cycles=%0d, expected 0", seen);
            end
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int cyc;
        launch(16'h0F00, 16'h0123, 1'b0);
        tick();
        // Competing request in the middle of RUN must not be captured.
        start = 1'b1; A = 16'hFFFF; B = 16'h0000; bin = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        n_vec++;
        if (cyc != 3) begin
            n_err++;
            $display("FAIL ignore_latency cycles=%0d, expected 3", cyc);
        end
        tick();
        // A captured second request would produce an extra done here.
        repeat (8) @(negedge Clk);
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(16'h1000, 16'h0001, 1'b0);
        wait_done(cyc);
        n_vec++;
        if (cyc != 5) begin
            n_err++;
            $display("FAIL b2b_first_latency cycles=%0d, expected 5", cyc);
        end
        // Still inside the DONE cycle: request the next operation now.
        launch(16'h0010, 16'h0001, 1'b0);
        wait_done(cyc);
        n_vec++;
        if (cyc != 5) begin
            n_err++;
            $display("FAIL b2b_second_latency cycles=%0d, expected 5", cyc);
        end
    endtask

    task automatic test_stability();
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            n_vec++;
            if (done !== 1'b0 || D !== last_exp.d || bout !== last_exp.bout || V !== last_exp.v) begin
                n_err++;
                $display("FAIL hold cycle=%0d done=%b D=%h bout=%b V=%b, expected 0 %h %b %b",
                         i, done, D, bout, V, last_exp.d, last_exp.bout, last_exp.v);
            end
        end
    endtask

    initial begin
        test_reset();
        tick();
        test_basic();
        test_borrow_ripple();
        test_overflow();
        test_reset_midrun();
        test_ignore_start();
        test_back_to_back();
        test_stability();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pending_results left=%0d, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
